// File: rtl/i2c_master_wr.sv
// Write-only open-drain I2C master: START, address+W, data bytes, STOP; HOLD chains bytes.
// Optional macro I2C_MASTER_STRETCH_EN freezes the Q2 counter while a slave stretches SCL.
module i2c_master_wr #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   inout  wire        scl,
   inout  wire        sda,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   input  logic       cmd_last,
   output logic       busy,
   output logic       done,
   output logic       nack
);

   localparam int DATA_W = 8;
   localparam int QW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_START    = 3'd1;
   localparam logic [2:0] S_ADDR     = 3'd2;
   localparam logic [2:0] S_ADDR_ACK = 3'd3;
   localparam logic [2:0] S_DATA     = 3'd4;
   localparam logic [2:0] S_DATA_ACK = 3'd5;
   localparam logic [2:0] S_HOLD     = 3'd6;
   localparam logic [2:0] S_STOP     = 3'd7;

   logic [2:0]        state;
   logic [QW-1:0]     qcnt;
   logic [1:0]        quarter;
   logic [2:0]        bitcnt;
   logic [6:0]        addr_r;
   logic [DATA_W-1:0] data_r;
   logic              last_r;
   logic              samp;
   logic              scl_low;
   logic              sda_low;
   logic              freeze;
   logic              running;
   logic              q_last;
   logic              bit_end;
   logic              accept;
   logic              cur_bit;
   logic [DATA_W-1:0] addr_byte;

`ifdef I2C_MASTER_STRETCH_EN
   // A slave holding SCL low in Q2 stalls the bit until it lets go.
   assign freeze = (quarter == 2'd2) && (scl == 1'b0);
`else
   assign freeze = 1'b0;
`endif

   assign running   = (state != S_IDLE) && (state != S_HOLD);
   assign q_last    = (qcnt == QW'(CLK_DIV - 1)) && !freeze;
   assign bit_end   = q_last && (quarter == 2'd3);
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != S_IDLE);
   assign addr_byte = {addr_r, 1'b0};
   assign cur_bit   = (state == S_ADDR) ? addr_byte[3'd7 - bitcnt] : data_r[3'd7 - bitcnt];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         qcnt      <= '0;
         quarter   <= 2'd0;
         bitcnt    <= 3'd0;
         samp      <= 1'b1;
         cmd_ready <= 1'b0;
         done      <= 1'b0;
         nack      <= 1'b0;
      end else begin
         done <= 1'b0;
         // Ready lags the state by a cycle, so entering HOLD never accepts in the same cycle.
         cmd_ready <= ((state == S_IDLE) || (state == S_HOLD)) && !accept;
         if (running && !freeze) begin
            if (q_last) begin
               qcnt    <= '0;
               quarter <= quarter + 2'd1;
            end else begin
               qcnt <= qcnt + QW'(1);
            end
         end
         if (running && q_last && (quarter == 2'd2)) samp <= sda;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  addr_r  <= cmd_addr;
                  data_r  <= cmd_data;
                  last_r  <= cmd_last;
                  nack    <= 1'b0;
                  state   <= S_START;
                  qcnt    <= '0;
                  quarter <= 2'd0;
               end
            end
            S_START: begin
               if (q_last && (quarter == 2'd1)) begin
                  state   <= S_ADDR;
                  quarter <= 2'd0;
                  bitcnt  <= 3'd0;
               end
            end
            S_ADDR, S_DATA: begin
               if (bit_end) begin
                  if (bitcnt == 3'd7) begin
                     state  <= (state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                     bitcnt <= 3'd0;
                  end else begin
                     bitcnt <= bitcnt + 3'd1;
                  end
               end
            end
            S_ADDR_ACK: begin
               if (bit_end) begin
                  if (samp) begin
                     nack  <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     state  <= S_DATA;
                     bitcnt <= 3'd0;
                  end
               end
            end
            S_DATA_ACK: begin
               if (bit_end) begin
                  if (samp) begin
                     nack  <= 1'b1;
                     state <= S_STOP;
                  end else if (last_r) begin
                     state <= S_STOP;
                  end else begin
                     state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (accept) begin
                  data_r  <= cmd_data;
                  last_r  <= cmd_last;
                  state   <= S_DATA;
                  qcnt    <= '0;
                  quarter <= 2'd0;
                  bitcnt  <= 3'd0;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Line drive is decoded from registered state, so a reset releases both lines at the next edge.
   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      case (state)
         S_START: sda_low = 1'b1;
         S_ADDR, S_DATA: begin
            scl_low = !quarter[1];
            sda_low = !cur_bit;
         end
         S_ADDR_ACK, S_DATA_ACK: scl_low = !quarter[1];
         S_HOLD: begin
            scl_low = 1'b1;
            sda_low = 1'b1;
         end
         S_STOP: begin
            scl_low = !quarter[1];
            sda_low = (quarter != 2'd3);
         end
         default: begin
            scl_low = 1'b0;
            sda_low = 1'b0;
         end
      endcase
   end

   assign scl = scl_low ? 1'b0 : 1'bz;
   assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Bench for i2c_master_wr: bus monitor/slave model feeding a token scoreboard plus latency checks.
module tb_i2c_master_wr;
   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   wire        scl;
   wire        sda;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [6:0] cmd_addr = 7'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       cmd_last = 1'b0;
   logic       busy;
   logic       done;
   logic       nack;

   logic s_scl_low = 1'b0;
   logic s_sda_low = 1'b0;

   pullup (scl);
   pullup (sda);
   assign scl = s_scl_low ? 1'b0 : 1'bz;
   assign sda = s_sda_low ? 1'b0 : 1'bz;

   i2c_master_wr #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .scl(scl), .sda(sda),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_last(cmd_last), .busy(busy), .done(done), .nack(nack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [12:0] exp_q[$];
   logic ack_addr = 1'b1;
   logic stretch_req = 1'b0;
   logic ready_bad = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [12:0] tok(input logic [3:0] ty, input logic [7:0] b, input logic a);
      return {ty, b, a};
   endfunction

   localparam logic [3:0] T_START = 4'd1;
   localparam logic [3:0] T_BYTE  = 4'd2;
   localparam logic [3:0] T_STOP  = 4'd3;

   task automatic sb_check(input logic [12:0] t);
      logic [12:0] e;
      if (exp_q.size() == 0) begin
         chk("sb_extra", t, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("sb_token", t, e);
      end
   endtask

   task automatic push_single(input logic [6:0] a, input logic [7:0] d);
      exp_q.push_back(tok(T_START, 8'h00, 1'b0));
      exp_q.push_back(tok(T_BYTE, {a, 1'b0}, 1'b0));
      exp_q.push_back(tok(T_BYTE, d, 1'b0));
      exp_q.push_back(tok(T_STOP, 8'h00, 1'b0));
   endtask

   // Slave model: decodes START/STOP/bytes on the bus, ACKs, optionally stretches the address ACK.
   logic pscl = 1'b1;
   logic psda = 1'b1;
   int   bits = 0;
   int   nbyte = 0;
   int   hold_cnt = 0;
   logic [7:0] sh = 8'h00;

   always @(negedge clk) begin
      logic c_scl;
      logic c_sda;
      c_scl = scl;
      c_sda = sda;
      if (hold_cnt > 0) begin
         hold_cnt--;
         if (hold_cnt == 0) s_scl_low = 1'b0;
      end
      if (pscl && c_scl && psda && !c_sda) begin
         bits = 0;
         nbyte = 0;
         s_sda_low = 1'b0;
         sb_check(tok(T_START, 8'h00, 1'b0));
      end else if (pscl && c_scl && !psda && c_sda) begin
         s_sda_low = 1'b0;
         sb_check(tok(T_STOP, 8'h00, 1'b0));
      end else if (!pscl && c_scl) begin
         if (bits < 8) sh = {sh[6:0], c_sda};
         bits++;
         if (bits == 9) begin
            sb_check(tok(T_BYTE, sh, c_sda));
            bits = 0;
            nbyte++;
         end
      end else if (pscl && !c_scl) begin
         if (bits == 8) begin
            if (nbyte != 0 || ack_addr) s_sda_low = 1'b1;
            if (stretch_req && nbyte == 0) begin
               s_scl_low = 1'b1;
               hold_cnt = 2 * CLK_DIV + 20;
            end
         end else if (bits == 0) begin
            s_sda_low = 1'b0;
         end
      end
      pscl = c_scl;
      psda = c_sda;
      if (!rst && busy && cmd_ready === 1'b1 && !(c_scl === 1'b0 && c_sda === 1'b0)) ready_bad = 1'b1;
   end

   task automatic wait_accept(input bit keep);
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", (n < 2000), 32'd1);
      @(posedge clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic issue(input logic [6:0] a, input logic [7:0] d, input logic l, input bit keep);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_last  = l;
      wait_accept(keep);
   endtask

   // Latency counted so that the cycle right after the accepting edge is 1.
   task automatic wait_done(output int lat, output logic f_scl, output logic f_sda,
                            output logic f_nack, output logic d_after);
      lat = 1;
      f_scl = 1'bx;
      f_sda = 1'bx;
      f_nack = 1'bx;
      forever begin
         @(negedge clk);
         if (lat == 1) begin
            f_scl = scl;
            f_sda = sda;
            f_nack = nack;
         end
         if (done === 1'b1 || lat >= 3000) break;
         @(posedge clk);
         lat++;
      end
      @(posedge clk);
      @(negedge clk);
      d_after = done;
   endtask

   initial begin
      int lat;
      int k;
      logic f_scl, f_sda, f_nack, d_after;
      logic gap_bad;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_nack", nack, 1'b0);
      chk("rst_scl", scl, 1'b1);
      chk("rst_sda", sda, 1'b1);
      rst = 1'b0;

      // Single write 0x42 / 0xA5.
      push_single(7'h42, 8'hA5);
      issue(7'h42, 8'hA5, 1'b1, 1'b0);
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("single_done_lat", lat, 32'd313);
      chk("single_start_sda", f_sda, 1'b0);
      chk("single_start_scl", f_scl, 1'b1);
      chk("single_nack", nack, 1'b0);
      chk("single_done_pulse", d_after, 1'b0);
      chk("single_sb_empty", exp_q.size(), 32'd0);

      // Command held valid across a busy transaction; it must wait for IDLE.
      push_single(7'h10, 8'h5A);
      issue(7'h10, 8'h5A, 1'b1, 1'b1);
      cmd_addr = 7'h55;
      cmd_data = 8'h3C;
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("busy_cmd_lat", lat, 32'd313);
      chk("busy_cmd_sb_empty", exp_q.size(), 32'd0);
      push_single(7'h55, 8'h3C);
      wait_accept(1'b0);
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("queued_cmd_lat", lat, 32'd313);
      chk("queued_cmd_sb_empty", exp_q.size(), 32'd0);

      // Two-byte write with a 50-cycle HOLD gap.
      exp_q.push_back(tok(T_START, 8'h00, 1'b0));
      exp_q.push_back(tok(T_BYTE, 8'h36, 1'b0));
      exp_q.push_back(tok(T_BYTE, 8'h11, 1'b0));
      exp_q.push_back(tok(T_BYTE, 8'h22, 1'b0));
      exp_q.push_back(tok(T_STOP, 8'h00, 1'b0));
      issue(7'h1B, 8'h11, 1'b0, 1'b0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (cmd_ready !== 1'b1 && k < 1000);
      chk("hold_ready_lat", k, 32'd298);
      gap_bad = !(scl === 1'b0 && sda === 1'b0);
      for (int i = 0; i < 49; i++) begin
         @(negedge clk);
         if (!(scl === 1'b0 && sda === 1'b0 && cmd_ready === 1'b1)) gap_bad = 1'b1;
      end
      chk("hold_gap_lines", gap_bad, 1'b0);
      cmd_valid = 1'b1;
      cmd_addr  = 7'h7F;
      cmd_data  = 8'h22;
      cmd_last  = 1'b1;
      wait_accept(1'b0);
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("hold_data_lat", lat, 32'd161);
      chk("hold_first_bit_scl", f_scl, 1'b0);
      chk("two_byte_sb_empty", exp_q.size(), 32'd0);

      // Address NACK.
      ack_addr = 1'b0;
      exp_q.push_back(tok(T_START, 8'h00, 1'b0));
      exp_q.push_back(tok(T_BYTE, 8'h84, 1'b1));
      exp_q.push_back(tok(T_STOP, 8'h00, 1'b0));
      issue(7'h42, 8'hA5, 1'b1, 1'b0);
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("nack_done_lat", lat, 32'd169);
      chk("nack_flag", nack, 1'b1);
      chk("nack_sb_empty", exp_q.size(), 32'd0);
      ack_addr = 1'b1;
      push_single(7'h33, 8'hC3);
      issue(7'h33, 8'hC3, 1'b1, 1'b0);
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("nack_cleared", f_nack, 1'b0);
      chk("after_nack_lat", lat, 32'd313);
      chk("after_nack_flag", nack, 1'b0);
      chk("after_nack_sb_empty", exp_q.size(), 32'd0);

      // Reset during data bit 3.
      exp_q.push_back(tok(T_START, 8'h00, 1'b0));
      exp_q.push_back(tok(T_BYTE, 8'h84, 1'b0));
      issue(7'h42, 8'hA5, 1'b1, 1'b0);
      repeat (206) @(negedge clk);
      chk("pre_rst_busy", busy, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_scl", scl, 1'b1);
      chk("mid_rst_sda", sda, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_done", done, 1'b0);
      chk("mid_rst_sb_empty", exp_q.size(), 32'd0);
      push_single(7'h42, 8'hA5);
      issue(7'h42, 8'hA5, 1'b1, 1'b0);
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("post_rst_lat", lat, 32'd313);
      chk("post_rst_nack", nack, 1'b0);
      chk("post_rst_sb_empty", exp_q.size(), 32'd0);

`ifdef I2C_MASTER_STRETCH_EN
      stretch_req = 1'b1;
      push_single(7'h42, 8'hA5);
      issue(7'h42, 8'hA5, 1'b1, 1'b0);
      wait_done(lat, f_scl, f_sda, f_nack, d_after);
      chk("stretch_lat", lat, 32'd333);
      chk("stretch_sb_empty", exp_q.size(), 32'd0);
      stretch_req = 1'b0;
`endif

      chk("ready_only_idle_hold", ready_bad, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
